// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, instruction field positions and types for the operand fetch stage.
// Build option: define OPFETCH_BYPASS_EN to forward EX/MEM results into the operands;
// leave it undefined for a full interlock on any in-flight producer match.
package operand_fetch_stage_pkg;

  localparam int unsigned ADDR_BIT_NUM = 5;
  localparam int unsigned RV_BIT_NUM   = 32;

  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = RS1_LSB + ADDR_BIT_NUM - 1;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = RS2_LSB + ADDR_BIT_NUM - 1;

`ifdef OPFETCH_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  typedef logic [ADDR_BIT_NUM-1:0] reg_addr_t;
  typedef logic [RV_BIT_NUM-1:0]   rv_word_t;

  // Where a resolved operand value comes from, in priority order.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_FWD,
    SRC_WB,
    SRC_RF
  } opnd_src_e;

  // The single holding slot between decode and execute.
  typedef struct packed {
    logic     valid;
    rv_word_t pc;
    rv_word_t instr;
  } slot_t;

endpackage

// File: rtl/operand_resolve.sv
// Resolves one source operand from x0, an in-flight producer, a same-cycle
// writeback captured last edge, or the registered regfile read data.
// Build option OPFETCH_BYPASS_EN selects forwarding versus full interlock.
module operand_resolve
  import operand_fetch_stage_pkg::*;
(
  input  logic [ADDR_BIT_NUM-1:0] rs_i,
  input  logic [RV_BIT_NUM-1:0]   rf_data_i,
  input  logic                    hit_q_i,
  input  logic [RV_BIT_NUM-1:0]   wd_q_i,
  input  logic                    fwd_wen_i,
  input  logic [ADDR_BIT_NUM-1:0] fwd_rd_i,
  input  logic [RV_BIT_NUM-1:0]   fwd_data_i,
  input  logic                    fwd_pending_i,
  output logic [RV_BIT_NUM-1:0]   value_o,
  output logic                    stall_o
);

  opnd_src_e src;
  logic      fwd_match;

  // Pick the source holding the youngest value of the register.
  always_comb begin
    fwd_match = fwd_wen_i && (fwd_rd_i == rs_i) && (rs_i != '0);
    src       = SRC_RF;
    if (rs_i == '0) begin
      src = SRC_ZERO;
    end else if (fwd_match) begin
      src = SRC_FWD;
    end else if (hit_q_i) begin
      src = SRC_WB;
    end
  end

  // Drive the selected value; an interlocked forward shows fwd_data but is never consumed.
  always_comb begin
    value_o = rf_data_i;
    case (src)
      SRC_ZERO: value_o = '0;
      SRC_FWD:  value_o = fwd_data_i;
      SRC_WB:   value_o = wd_q_i;
      default:  value_o = rf_data_i;
    endcase
  end

  // Forwarding waits only on a pending producer; the interlock waits on any matching producer.
  always_comb begin
    stall_o = fwd_match & (fwd_pending_i | ~BYPASS_EN);
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch half of decode/issue: holds one instruction, drives the regfile
// read addresses, patches write-after-read collisions and in-flight producers.
// Build option: OPFETCH_BYPASS_EN (forwarding) vs. undefined (full interlock).
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RV_BIT_NUM-1:0]   in_pc,
  input  logic [RV_BIT_NUM-1:0]   in_instr,
  output logic [ADDR_BIT_NUM-1:0] rf_rs1_addr,
  output logic [ADDR_BIT_NUM-1:0] rf_rs2_addr,
  input  logic [RV_BIT_NUM-1:0]   rf_rs1_data,
  input  logic [RV_BIT_NUM-1:0]   rf_rs2_data,
  input  logic                    wb_wen,
  input  logic [ADDR_BIT_NUM-1:0] wb_waddr,
  input  logic [RV_BIT_NUM-1:0]   wb_wdata,
  input  logic                    fwd_wen,
  input  logic [ADDR_BIT_NUM-1:0] fwd_rd,
  input  logic [RV_BIT_NUM-1:0]   fwd_data,
  input  logic                    fwd_pending,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RV_BIT_NUM-1:0]   out_pc,
  output logic [RV_BIT_NUM-1:0]   out_instr,
  output logic [RV_BIT_NUM-1:0]   out_rs1,
  output logic [RV_BIT_NUM-1:0]   out_rs2
);

  slot_t     s1_q, s1_d;
  logic      hit1_q, hit1_d, hit2_q, hit2_d;
  rv_word_t  wd1_q, wd1_d, wd2_q, wd2_d;
  logic      fire, out_hs, stall1, stall2;
  reg_addr_t s1_rs1, s1_rs2;

  assign s1_rs1 = s1_q.instr[RS1_MSB:RS1_LSB];
  assign s1_rs2 = s1_q.instr[RS2_MSB:RS2_LSB];

  // Handshakes; fire is masked during reset so the read addresses sit at zero.
  always_comb begin
    out_valid = s1_q.valid & ~(stall1 | stall2);
    out_hs    = out_valid & out_ready;
    in_ready  = ~s1_q.valid | out_hs;
    fire      = rst_n & in_valid & in_ready;
  end

  // Read addresses follow the incoming instruction on fire, else re-read the held one every cycle.
  always_comb begin
    rf_rs1_addr = s1_rs1;
    rf_rs2_addr = s1_rs2;
    if (fire) begin
      rf_rs1_addr = in_instr[RS1_MSB:RS1_LSB];
      rf_rs2_addr = in_instr[RS2_MSB:RS2_LSB];
    end
  end

  // Slot next state: flush beats fire, fire beats the output handshake.
  always_comb begin
    s1_d = s1_q;
    if (flush) begin
      s1_d.valid = 1'b0;
    end else if (fire) begin
      s1_d = '{valid: 1'b1, pc: in_pc, instr: in_instr};
    end else if (out_hs) begin
      s1_d.valid = 1'b0;
    end
  end

  // The regfile returns pre-write data on a same-edge collision, so capture the write here.
  always_comb begin
    hit1_d = wb_wen && (wb_waddr == rf_rs1_addr) && (rf_rs1_addr != '0);
    hit2_d = wb_wen && (wb_waddr == rf_rs2_addr) && (rf_rs2_addr != '0);
    wd1_d  = wb_wdata;
    wd2_d  = wb_wdata;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      wd1_q  <= '0;
      wd2_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      wd1_q  <= wd1_d;
      wd2_q  <= wd2_d;
    end
  end

  operand_resolve u_resolve_rs1 (
    .rs_i          (s1_rs1),
    .rf_data_i     (rf_rs1_data),
    .hit_q_i       (hit1_q),
    .wd_q_i        (wd1_q),
    .fwd_wen_i     (fwd_wen),
    .fwd_rd_i      (fwd_rd),
    .fwd_data_i    (fwd_data),
    .fwd_pending_i (fwd_pending),
    .value_o       (out_rs1),
    .stall_o       (stall1)
  );

  operand_resolve u_resolve_rs2 (
    .rs_i          (s1_rs2),
    .rf_data_i     (rf_rs2_data),
    .hit_q_i       (hit2_q),
    .wd_q_i        (wd2_q),
    .fwd_wen_i     (fwd_wen),
    .fwd_rd_i      (fwd_rd),
    .fwd_data_i    (fwd_data),
    .fwd_pending_i (fwd_pending),
    .value_o       (out_rs2),
    .stall_o       (stall2)
  );

  assign out_pc    = s1_q.pc;
  assign out_instr = s1_q.instr;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: regfile environment, architectural
// reference model, directed vector table, hand sequences and random traffic.
module tb_operand_fetch_stage;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        fwd_wen;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        fwd_pending;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_rs1, out_rs2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2)
  );

  // Register file environment: registered read, old data on same-edge write, x0 hardwired.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    rf_rs1_data <= (rf_rs1_addr == 5'd0) ? 32'h0 : mem[rf_rs1_addr];
    rf_rs2_data <= (rf_rs2_addr == 5'd0) ? 32'h0 : mem[rf_rs2_addr];
    if (wb_wen && wb_waddr != 5'd0) mem[wb_waddr] <= wb_wdata;
  end

  // Reference model: the slot plus architectural register state.
  logic        m_valid;
  logic [31:0] m_pc, m_instr;

  function automatic logic [31:0] arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : mem[r];
  endfunction

  function automatic bit fmatch(input logic [4:0] rs);
    return (rs != 5'd0) && fwd_wen && (fwd_rd == rs);
  endfunction

  function automatic bit exp_stall(input logic [4:0] rs);
    return fmatch(rs) && (!BYP || fwd_pending);
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs);
    return (BYP && fmatch(rs)) ? fwd_data : arch(rs);
  endfunction

  function automatic bit exp_out_valid();
    return m_valid && !exp_stall(m_instr[19:15]) && !exp_stall(m_instr[24:20]);
  endfunction

  function automatic bit exp_in_ready();
    return !m_valid || (exp_out_valid() && out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && exp_in_ready()) begin
      m_valid <= 1'b1;
      m_pc    <= in_pc;
      m_instr <= in_instr;
    end else if (exp_out_valid() && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit ev, ir;
    ev = exp_out_valid();
    ir = exp_in_ready();
    chk("in_ready", {31'h0, in_ready}, {31'h0, ir});
    chk("out_valid", {31'h0, out_valid}, {31'h0, ev});
    if (ev) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_instr", out_instr, m_instr);
      chk("out_rs1", out_rs1, exp_val(m_instr[19:15]));
      chk("out_rs2", out_rs2, exp_val(m_instr[24:20]));
    end
    if (!rst_n) begin
      chk("rf_addr_rst", {22'h0, rf_rs1_addr, rf_rs2_addr}, 32'h0);
    end else if (in_valid && ir) begin
      chk("rf_addr_in", {22'h0, rf_rs1_addr, rf_rs2_addr}, {22'h0, in_instr[19:15], in_instr[24:20]});
    end else if (m_valid) begin
      chk("rf_addr_s1", {22'h0, rf_rs1_addr, rf_rs2_addr}, {22'h0, m_instr[19:15], m_instr[24:20]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b);
    return {7'h00, b, a, 3'b000, 5'd1, 7'h33};
  endfunction

  function automatic logic [31:0] preval(input int unsigned r);
    if (r == 5) return 32'h1234;
    if (r == 7) return 32'h7070;
    return 32'(r) << 8;
  endfunction

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        fe;
    logic [4:0]  frd;
    logic [31:0] fd;
    logic        fp;
    logic        ev;
    logic [31:0] e1, e2;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  initial begin
    // Directed vectors: issue with wb fields in the fire cycle, forward fields in the next.
    tbl[0]  = '{5'd5,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 32'h1234,   32'h0};
    tbl[1]  = '{5'd5,  5'd3,  1'b1, 5'd5,  32'hBEEF,   1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 32'hBEEF,   32'h300};
    tbl[2]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFF,   1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 32'h0,      32'h0};
    tbl[3]  = '{5'd6,  5'd6,  1'b1, 5'd9,  32'h999,    1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 32'h600,    32'h600};
    tbl[4]  = '{5'd5,  5'd2,  1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'hA5A5,   1'b0, BYP,  32'hA5A5,   32'h200};
    tbl[5]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b1, 5'd0,  32'h5555,   1'b1, 1'b1, 32'h0,      32'h0};
    tbl[6]  = '{5'd1,  5'd4,  1'b0, 5'd0,  32'h0,      1'b1, 5'd4,  32'h4040,   1'b1, 1'b0, 32'h100,    32'h4040};
    tbl[7]  = '{5'd1,  5'd4,  1'b0, 5'd0,  32'h0,      1'b0, 5'd4,  32'hDEAD,   1'b0, 1'b1, 32'h100,    32'h400};
    tbl[8]  = '{5'd8,  5'd0,  1'b1, 5'd8,  32'h88,     1'b1, 5'd8,  32'hF0F0,   1'b0, BYP,  32'hF0F0,   32'h0};
    tbl[9]  = '{5'd3,  5'd10, 1'b1, 5'd10, 32'hAAAA,   1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 32'h300,    32'hAAAA};
    tbl[10] = '{5'd31, 5'd31, 1'b0, 5'd0,  32'h0,      1'b1, 5'd30, 32'h3030,   1'b1, 1'b1, 32'h1F00,   32'h1F00};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0;
    wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    fwd_wen = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0; fwd_pending = 1'b0; out_ready = 1'b1;

    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_rf_addr", {22'h0, rf_rs1_addr, rf_rs2_addr}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Preload the register file through the writeback port.
    for (int unsigned r = 1; r < 32; r++) begin
      tick();
      wb_wen = 1'b1; wb_waddr = 5'(r); wb_wdata = preval(r);
      sample();
    end
    tick();
    wb_wen = 1'b0;
    sample();

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      tick();
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(i) * 4; in_instr = mk(tbl[i].rs1, tbl[i].rs2);
      wb_wen = tbl[i].wbe; wb_waddr = tbl[i].wba; wb_wdata = tbl[i].wbd;
      sample();
      tick();
      in_valid = 1'b0; wb_wen = 1'b0;
      fwd_wen = tbl[i].fe; fwd_rd = tbl[i].frd; fwd_data = tbl[i].fd; fwd_pending = tbl[i].fp;
      sample();
      chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_rs1", i), out_rs1, tbl[i].e1);
        chk($sformatf("vec%0d_rs2", i), out_rs2, tbl[i].e2);
      end
      tick();
      fwd_wen = 1'b0; fwd_pending = 1'b0;
      sample();
      if (!tbl[i].ev) begin
        chk($sformatf("vec%0d_resume", i), {31'h0, out_valid}, 32'h1);
        tick();
        sample();
      end
    end

    // Load-use: pending producer on rs2 for three cycles holds both ports.
    tick();
    in_valid = 1'b1; in_pc = 32'h2000; in_instr = mk(5'd1, 5'd4);
    sample();
    for (int k = 0; k < 3; k++) begin
      tick();
      in_pc = 32'h2004; in_instr = mk(5'd2, 5'd3);
      fwd_wen = 1'b1; fwd_rd = 5'd4; fwd_data = 32'h4444; fwd_pending = 1'b1;
      sample();
      chk("lu_out_valid", {31'h0, out_valid}, 32'h0);
      chk("lu_in_ready", {31'h0, in_ready}, 32'h0);
    end
    tick();
    fwd_pending = 1'b0;
    sample();
    chk("lu_ready_valid", {31'h0, out_valid}, {31'h0, BYP});
    if (out_valid) chk("lu_fwd_rs2", out_rs2, 32'h4444);
    tick();
    fwd_wen = 1'b0;
    sample();
    chk("lu_after_valid", {31'h0, out_valid}, 32'h1);
    chk("lu_after_rs2", out_rs2, BYP ? 32'h300 : 32'h400);
    tick();
    in_valid = 1'b0;
    sample();
    tick();
    sample();

    // Backpressure: held instruction re-reads x7 while writeback keeps changing it.
    tick();
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = mk(5'd7, 5'd7); out_ready = 1'b0;
    sample();
    for (int k = 1; k <= 4; k++) begin
      tick();
      in_valid = 1'b0; wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h7000 + 32'(k);
      sample();
      chk($sformatf("bp%0d_rs1", k), out_rs1, (k == 1) ? 32'h7070 : 32'h7000 + 32'(k - 1));
    end
    tick();
    wb_wen = 1'b0;
    sample();
    chk("bp_final_rs1", out_rs1, 32'h7004);
    chk("bp_final_rs2", out_rs2, 32'h7004);

    // Flush while held and an incoming instruction waits.
    tick();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3004; in_instr = mk(5'd1, 5'd2);
    sample();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sample();
    chk("fl_out_valid", {31'h0, out_valid}, 32'h0);
    chk("fl_in_ready", {31'h0, in_ready}, 32'h1);
    // Flush with an empty slot: the accepted instruction is dropped as well.
    tick();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3008;
    sample();
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sample();
    chk("fl2_out_valid", {31'h0, out_valid}, 32'h0);

    // Reset mid-stream with a held instruction and another waiting.
    tick();
    in_valid = 1'b1; in_pc = 32'h4000; in_instr = mk(5'd9, 5'd10); out_ready = 1'b0;
    sample();
    tick();
    in_pc = 32'h4004; in_instr = mk(5'd11, 5'd12);
    sample();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mrst_rf_addr", {22'h0, rf_rs1_addr, rf_rs2_addr}, 32'h0);
    tick();
    sample();
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sample();

    // Random traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      tick();
      in_valid    = ($urandom_range(0, 1) == 1);
      in_pc       = $urandom;
      in_instr    = $urandom;
      in_instr[19:15] = 5'($urandom_range(0, 7));
      in_instr[24:20] = 5'($urandom_range(0, 7));
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      wb_wen      = ($urandom_range(0, 1) == 1);
      wb_waddr    = 5'($urandom_range(0, 7));
      wb_wdata    = $urandom;
      fwd_wen     = ($urandom_range(0, 2) == 0);
      fwd_rd      = 5'($urandom_range(0, 7));
      fwd_data    = $urandom;
      fwd_pending = ($urandom_range(0, 1) == 1);
      sample();
    end

    tick();
    in_valid = 1'b0; flush = 1'b0; wb_wen = 1'b0; fwd_wen = 1'b0;
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
